// File: rtl/step_pulse_gen.sv
// rtl/step_pulse_gen.sv - button debounce, press strobe and auto-advance step pulse generator
//
// Conditions a raw, bouncing push-button and an auto-mode switch into a clean
// single-cycle advance strobe for a downstream state machine.
//
// Ports:
//   clk        in   1  system clock
//   rst_n      in   1  synchronous active-low reset
//   btn_in     in   1  raw button, asynchronous, may bounce
//   auto_en    in   1  raw auto-advance switch, asynchronous, quasi-static
//   step       out  1  one-cycle advance strobe
//   btn_state  out  1  debounced button level
//   step_count out  8  number of step pulses issued, modulo 256

module step_pulse_gen #(
    parameter logic [15:0] DB_COUNT   = 16'd50_000,
    parameter logic [23:0] TICK_COUNT = 24'd10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_in,
    input  logic       auto_en,
    output logic       step,
    output logic       btn_state,
    output logic [7:0] step_count
);

    // Synchroniser stages
    logic        b_s1_q, b_s1_d;
    logic        b_s2_q, b_s2_d;
    logic        a_s1_q, a_s1_d;
    logic        a_s2_q, a_s2_d;

    // Debounce
    logic        btn_state_q, btn_state_d;
    logic [15:0] db_cnt_q, db_cnt_d;
    logic        btn_d_q, btn_d_d;

    // Auto timer and output strobe
    logic [23:0] tcnt_q, tcnt_d;
    logic        step_q, step_d;
    logic [7:0]  step_count_q, step_count_d;

    // Events
    logic        press;
    logic        tick;
    logic        tcnt_last;

    always_comb begin
        b_s1_d = btn_in;
        b_s2_d = b_s1_q;
        a_s1_d = auto_en;
        a_s2_d = a_s1_q;
    end

    // A changed level must persist for DB_COUNT consecutive cycles; any
    // cycle back at the accepted level clears the run.
    always_comb begin
        btn_state_d = btn_state_q;
        db_cnt_d    = 16'd0;
        if (b_s2_q != btn_state_q) begin
            if (db_cnt_q == DB_COUNT - 16'd1) begin
                btn_state_d = b_s2_q;
                db_cnt_d    = 16'd0;
            end else begin
                db_cnt_d = db_cnt_q + 16'd1;
            end
        end
        btn_d_d = btn_state_q;
    end

    // Rising edge of the debounced level only; releases are ignored.
    always_comb begin
        press = btn_state_q & ~btn_d_q;
    end

    // A manual press re-phases the timer and swallows a coincident tick, so
    // a collision produces one strobe and the next tick is a full period on.
    always_comb begin
        tcnt_last = (tcnt_q == TICK_COUNT - 24'd1);
        tick      = a_s2_q & tcnt_last & ~press;
        tcnt_d    = tcnt_q + 24'd1;
        if (!a_s2_q || press || tcnt_last) begin
            tcnt_d = 24'd0;
        end
    end

    // Counter advances in the same edge that raises step.
    always_comb begin
        step_d       = press | tick;
        step_count_d = step_count_q;
        if (step_d) begin
            step_count_d = step_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            b_s1_q       <= 1'b0;
            b_s2_q       <= 1'b0;
            a_s1_q       <= 1'b0;
            a_s2_q       <= 1'b0;
            btn_state_q  <= 1'b0;
            db_cnt_q     <= 16'd0;
            btn_d_q      <= 1'b0;
            tcnt_q       <= 24'd0;
            step_q       <= 1'b0;
            step_count_q <= 8'd0;
        end else begin
            b_s1_q       <= b_s1_d;
            b_s2_q       <= b_s2_d;
            a_s1_q       <= a_s1_d;
            a_s2_q       <= a_s2_d;
            btn_state_q  <= btn_state_d;
            db_cnt_q     <= db_cnt_d;
            btn_d_q      <= btn_d_d;
            tcnt_q       <= tcnt_d;
            step_q       <= step_d;
            step_count_q <= step_count_d;
        end
    end

    assign step       = step_q;
    assign btn_state  = btn_state_q;
    assign step_count = step_count_q;

endmodule
